// File: rtl/ghost_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ghost_pkg: shared types for the ghost move sequencer                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ghost_pkg;

  localparam int NUM_GHOSTS = 4;

  typedef enum logic [1:0] {
    DIR_U = 2'b00,
    DIR_R = 2'b01,
    DIR_D = 2'b10,
    DIR_L = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_DRAIN  = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } seq_state_t;

  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ghost_move_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ghost_move_sequencer_if: maze wall ROM read port                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface ghost_move_sequencer_if #(
  parameter int COORD_W = 5
);
  logic               mazeRdEn;
  logic [COORD_W-1:0] mazeAddrX;
  logic [COORD_W-1:0] mazeAddrY;
  logic               mazeWall;

  modport master (output mazeRdEn, output mazeAddrX, output mazeAddrY, input mazeWall);
  modport slave  (input mazeRdEn, input mazeAddrX, input mazeAddrY, output mazeWall);
endinterface
`default_nettype wire

// File: rtl/maze_neighbor_addr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | maze_neighbor_addr: neighbour tile of (x,y) in a direction, with     |
// | tunnel wrap on both axes.  Revision: 1.0                             |
// +----------------------------------------------------------------------+
module maze_neighbor_addr
  import ghost_pkg::*;
#(
  parameter int GRID_W  = 28,
  parameter int GRID_H  = 31,
  parameter int COORD_W = 5
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  dir_t               dir,
  output logic [COORD_W-1:0] nx,
  output logic [COORD_W-1:0] ny
);
  localparam logic [COORD_W-1:0] c_MAX_X = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] c_MAX_Y = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] c_ONE   = COORD_W'(1);

  always_comb begin
    nx = x;
    ny = y;
    case (dir)
      DIR_U:   ny = (y == '0)      ? c_MAX_Y : y - c_ONE;
      DIR_D:   ny = (y == c_MAX_Y) ? '0      : y + c_ONE;
      DIR_L:   nx = (x == '0)      ? c_MAX_X : x - c_ONE;
      default: nx = (x == c_MAX_X) ? '0      : x + c_ONE;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/ghost_move_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ghost_move_sequencer: per tick, reads the 4 neighbour walls of each  |
// | ghost from one shared ROM port and strobes that ghost's update.      |
// | Optional macro GHOST_NO_REVERSE_EN: suppress reversing directions.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ghost_move_sequencer
  import ghost_pkg::*;
#(
  parameter int GRID_W  = 28,
  parameter int GRID_H  = 31,
  parameter int COORD_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic [4*COORD_W-1:0]   ghostPosX,
  input  logic [4*COORD_W-1:0]   ghostPosY,
  input  logic [7:0]             dirToMove,
  ghost_move_sequencer_if.master rom,
  output logic [1:0]             ghostSel,
  output logic                   canMoveU,
  output logic                   canMoveR,
  output logic                   canMoveD,
  output logic                   canMoveL,
  output logic [3:0]             update,
  output logic                   busy,
  output logic                   done,
  output logic                   tickOverrun
);
  seq_state_t         r_state;
  seq_state_t         w_next;
  logic [1:0]         r_g;
  logic [1:0]         r_k;
  logic [2:0]         r_raw;
  logic [3:0]         r_can;
  logic               r_ovr;
  logic [3:0]         w_raw;
  logic [3:0]         w_filt;
  logic [COORD_W-1:0] w_gx;
  logic [COORD_W-1:0] w_gy;
  logic [COORD_W-1:0] w_nx;
  logic [COORD_W-1:0] w_ny;

  assign w_gx = ghostPosX[r_g*COORD_W +: COORD_W];
  assign w_gy = ghostPosY[r_g*COORD_W +: COORD_W];

  maze_neighbor_addr #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .COORD_W(COORD_W)
  ) u_nbr (
    .x  (w_gx),
    .y  (w_gy),
    .dir(dir_t'(r_k)),
    .nx (w_nx),
    .ny (w_ny)
  );

  // Word k arrives one cycle after read k; bits end up ordered {L,D,R,U}.
  assign w_raw = {~rom.mazeWall, r_raw};

`ifdef GHOST_NO_REVERSE_EN
  dir_t       r_last_dir [NUM_GHOSTS];
  logic [3:0] r_last_valid;
  logic [3:0] w_masked;

  always_comb begin
    w_masked = w_raw & ~(4'b0001 << opposite(r_last_dir[r_g]));
    w_filt   = (r_last_valid[r_g] && (w_masked != 4'b0000)) ? w_masked : w_raw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_valid <= 4'b0000;
      for (int i = 0; i < NUM_GHOSTS; i++) r_last_dir[i] <= DIR_U;
    end else if (r_state == S_UPDATE) begin
      r_last_dir[r_g]   <= dir_t'(dirToMove[2*r_g +: 2]);
      r_last_valid[r_g] <= 1'b1;
    end
  end
`else
  logic w_unused_dir;
  assign w_unused_dir = ^dirToMove;
  assign w_filt       = w_raw;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (tick) w_next = S_READ;
      S_READ:   if (r_k == 2'd3) w_next = S_DRAIN;
      S_DRAIN:  w_next = S_UPDATE;
      S_UPDATE: w_next = (r_g == 2'd3) ? S_DONE : S_READ;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    rom.mazeRdEn  = 1'b0;
    rom.mazeAddrX = '0;
    rom.mazeAddrY = '0;
    update        = 4'b0000;
    done          = 1'b0;
    busy          = (r_state != S_IDLE);
    case (r_state)
      S_READ: begin
        rom.mazeRdEn  = 1'b1;
        rom.mazeAddrX = w_nx;
        rom.mazeAddrY = w_ny;
      end
      S_UPDATE: update = 4'b0001 << r_g;
      S_DONE:   done   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_g   <= 2'd0;
      r_k   <= 2'd0;
      r_raw <= 3'b000;
      r_can <= 4'b0000;
      r_ovr <= 1'b0;
    end else begin
      if (tick && (r_state != S_IDLE)) r_ovr <= 1'b1;
      case (r_state)
        S_IDLE: if (tick) begin
          r_g <= 2'd0;
          r_k <= 2'd0;
        end
        S_READ: begin
          r_k <= r_k + 2'd1;
          if (r_k != 2'd0) r_raw <= {~rom.mazeWall, r_raw[2:1]};
        end
        S_DRAIN:  r_can <= w_filt;
        S_UPDATE: if (r_g != 2'd3) r_g <= r_g + 2'd1;
        default: ;
      endcase
    end
  end

  assign ghostSel    = r_g;
  assign canMoveU    = r_can[0];
  assign canMoveR    = r_can[1];
  assign canMoveD    = r_can[2];
  assign canMoveL    = r_can[3];
  assign tickOverrun = r_ovr;
endmodule
`default_nettype wire

// File: tb/tb_ghost_move_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ghost_move_sequencer: randomized + directed bench with a tile-    |
// | level reference model of the move permissions.  Revision: 1.0       |
// +----------------------------------------------------------------------+
module tb_ghost_move_sequencer;
  localparam int GW = 28;
  localparam int GH = 31;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tick = 1'b0;
  logic [4*CW-1:0] ghostPosX = '0;
  logic [4*CW-1:0] ghostPosY = '0;
  logic [7:0]    dirToMove = '0;
  logic [1:0]    ghostSel;
  logic          canMoveU, canMoveR, canMoveD, canMoveL;
  logic [3:0]    update;
  logic          busy, done, tickOverrun;

  ghost_move_sequencer_if #(.COORD_W(CW)) rom_if ();

  ghost_move_sequencer #(.GRID_W(GW), .GRID_H(GH), .COORD_W(CW)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .ghostPosX(ghostPosX), .ghostPosY(ghostPosY), .dirToMove(dirToMove),
    .rom(rom_if),
    .ghostSel(ghostSel), .canMoveU(canMoveU), .canMoveR(canMoveR),
    .canMoveD(canMoveD), .canMoveL(canMoveL), .update(update),
    .busy(busy), .done(done), .tickOverrun(tickOverrun)
  );

  always #5 clk = ~clk;

  bit   wall [32][32];
  logic next_data;
  int   rd_x_q[$];
  int   rd_y_q[$];

  // Single-cycle-latency ROM model plus a log of every read address.
  always @(negedge clk) begin
    next_data = (rom_if.mazeRdEn === 1'b1) ? wall[rom_if.mazeAddrX][rom_if.mazeAddrY] : 1'b0;
    if (rom_if.mazeRdEn === 1'b1) begin
      rd_x_q.push_back(int'(rom_if.mazeAddrX));
      rd_y_q.push_back(int'(rom_if.mazeAddrY));
    end
  end
  always @(posedge clk) rom_if.mazeWall <= next_data;

  int         px[4], py[4];
  int         mdir[4];
  int         last_dir[4];
  bit         last_valid[4];
  logic [3:0] obs_can[4];
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic set_walls(input int mode);
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++)
        wall[x][y] = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom % 2);
  endtask

  task automatic apply_inputs();
    for (int g = 0; g < 4; g++) begin
      ghostPosX[g*CW +: CW] = CW'(px[g]);
      ghostPosY[g*CW +: CW] = CW'(py[g]);
      dirToMove[2*g +: 2]   = 2'(mdir[g]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int g = 0; g < 4; g++) last_valid[g] = 1'b0;
  endtask

  task automatic run_round(input string tag);
    int ex[4][4], ey[4][4];
    logic [3:0] exp_can[4];
    logic [3:0] exp_upd, got;
    logic [3:0] raw, m;
    int g;
    for (int gi = 0; gi < 4; gi++) begin
      ex[gi][0] = px[gi];               ey[gi][0] = (py[gi] + GH - 1) % GH;
      ex[gi][1] = (px[gi] + 1) % GW;    ey[gi][1] = py[gi];
      ex[gi][2] = px[gi];               ey[gi][2] = (py[gi] + 1) % GH;
      ex[gi][3] = (px[gi] + GW - 1) % GW; ey[gi][3] = py[gi];
      for (int k = 0; k < 4; k++) raw[k] = ~wall[ex[gi][k]][ey[gi][k]];
`ifdef GHOST_NO_REVERSE_EN
      if (last_valid[gi]) begin
        m = raw;
        m[(last_dir[gi] + 2) % 4] = 1'b0;
        if (m != 4'b0000) raw = m;
      end
      last_dir[gi]   = mdir[gi];
      last_valid[gi] = 1'b1;
`endif
      exp_can[gi] = raw;
    end
    apply_inputs();
    rd_x_q.delete();
    rd_y_q.delete();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      exp_upd = (n % 6 == 0 && n <= 24) ? (4'b0001 << (n / 6 - 1)) : 4'b0000;
      n_checks++;
      if (busy !== 1'b1 || update !== exp_upd || done !== (n == 25)) begin
        n_fail++;
        $display("FAIL %s cycle %0d: busy=%b update=%b done=%b, required busy=1 update=%b done=%b",
                 tag, n, busy, update, done, exp_upd, (n == 25));
      end
      if (exp_upd != 4'b0000) begin
        g = n / 6 - 1;
        got = {canMoveL, canMoveD, canMoveR, canMoveU};
        obs_can[g] = got;
        n_checks++;
        if (got !== exp_can[g] || ghostSel !== 2'(g)) begin
          n_fail++;
          $display("FAIL %s canMove ghost %0d: got LDRU=%b sel=%0d, required %b sel=%0d",
                   tag, g, got, ghostSel, exp_can[g], g);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after round: busy=%b done=%b, required 0 0", tag, busy, done);
    end
    n_checks++;
    if (rd_x_q.size() != 16) begin
      n_fail++;
      $display("FAIL %s read count: got %0d, required 16", tag, rd_x_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (rd_x_q[i] != ex[i/4][i%4] || rd_y_q[i] != ey[i/4][i%4]) begin
          n_fail++;
          $display("FAIL %s read addr %0d: got (%0d,%0d), required (%0d,%0d)",
                   tag, i, rd_x_q[i], rd_y_q[i], ex[i/4][i%4], ey[i/4][i%4]);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (busy !== 0 || done !== 0 || update !== 0 || tickOverrun !== 0 || ghostSel !== 0 ||
        {canMoveL, canMoveD, canMoveR, canMoveU} !== 4'b0000 || rom_if.mazeRdEn !== 0 ||
        rom_if.mazeAddrX !== 0 || rom_if.mazeAddrY !== 0) begin
      n_fail++;
      $display("FAIL reset state: busy=%b done=%b upd=%b ovr=%b sel=%0d can=%b rd=%b, required all 0",
               busy, done, update, tickOverrun, ghostSel,
               {canMoveL, canMoveD, canMoveR, canMoveU}, rom_if.mazeRdEn);
    end
  endtask

  task automatic test_open_maze();
    set_walls(0);
    for (int g = 0; g < 4; g++) begin px[g] = 10; py[g] = 10; mdir[g] = g; end
    run_round("open_maze");
    for (int g = 0; g < 4; g++) begin
      n_checks++;
      if (obs_can[g] !== 4'b1111) begin
        n_fail++;
        $display("FAIL open_maze ghost %0d: got %b, required 1111", g, obs_can[g]);
      end
    end
  endtask

  task automatic test_tunnel();
    do_reset();
    set_walls(1);
    wall[27][14] = 1'b0;
    wall[1][14]  = 1'b0;
    for (int g = 0; g < 4; g++) begin px[g] = 5; py[g] = 5; mdir[g] = 0; end
    px[2] = 0; py[2] = 14;
    run_round("tunnel");
    n_checks++;
    if (obs_can[2] !== 4'b1010) begin
      n_fail++;
      $display("FAIL tunnel ghost 2: got LDRU=%b, required 1010", obs_can[2]);
    end
  endtask

  task automatic test_corner();
    do_reset();
    set_walls(1);
    for (int g = 0; g < 4; g++) begin px[g] = 3; py[g] = 3; mdir[g] = 1; end
    px[3] = 27; py[3] = 30;
    run_round("corner");
    n_checks++;
    if (obs_can[3] !== 4'b0000) begin
      n_fail++;
      $display("FAIL corner ghost 3: got %b, required 0000", obs_can[3]);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      set_walls(2);
      for (int g = 0; g < 4; g++) begin
        px[g] = $urandom_range(0, GW - 1);
        py[g] = $urandom_range(0, GH - 1);
        mdir[g] = $urandom_range(0, 3);
      end
      if (r == 3) begin px[0] = GW - 1; py[1] = 0; px[2] = 0; py[3] = GH - 1; end
      run_round($sformatf("random%0d", r));
    end
  endtask

  task automatic test_overrun();
    int done_cnt = 0;
    int upd_cnt = 0;
    apply_inputs();
    tick = 1'b1;
    for (int c = 2; c <= 45; c++) begin
      @(negedge clk);
      tick = (c == 10);
      if (c == 10 || c == 11) begin
        n_checks++;
        if (tickOverrun !== (c == 11)) begin
          n_fail++;
          $display("FAIL overrun flag cycle %0d: got %b, required %b", c, tickOverrun, (c == 11));
        end
      end
      if (done === 1'b1) done_cnt++;
      upd_cnt += $countones(update);
    end
`ifdef GHOST_NO_REVERSE_EN
    for (int g = 0; g < 4; g++) begin last_dir[g] = mdir[g]; last_valid[g] = 1'b1; end
`endif
    n_checks++;
    if (done_cnt != 1 || upd_cnt != 4 || tickOverrun !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun round: done=%0d updates=%0d ovr=%b busy=%b, required 1 4 1 0",
               done_cnt, upd_cnt, tickOverrun, busy);
    end
  endtask

  task automatic test_mid_reset();
    int bad = 0;
    set_walls(0);
    for (int g = 0; g < 4; g++) begin px[g] = 12; py[g] = 20; mdir[g] = 3; end
    apply_inputs();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 0 || update !== 0 || {canMoveL, canMoveD, canMoveR, canMoveU} !== 4'b0000 ||
        rom_if.mazeRdEn !== 0 || tickOverrun !== 0 || ghostSel !== 0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b upd=%b can=%b rd=%b ovr=%b sel=%0d, required all 0",
               busy, update, {canMoveL, canMoveD, canMoveR, canMoveU}, rom_if.mazeRdEn,
               tickOverrun, ghostSel);
    end
    reset = 1'b0;
    for (int g = 0; g < 4; g++) last_valid[g] = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done !== 1'b0 || update !== 4'b0000 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mid_reset idle: %0d active cycles after abort, required 0", bad);
    end
    run_round("restart");
  endtask

`ifdef GHOST_NO_REVERSE_EN
  task automatic test_no_reverse();
    do_reset();
    set_walls(0);
    for (int g = 0; g < 4; g++) begin px[g] = 10; py[g] = 10; mdir[g] = 1; end
    run_round("norev1");
    run_round("norev2");
    n_checks++;
    if (obs_can[0] !== 4'b0111) begin
      n_fail++;
      $display("FAIL norev corridor ghost 0: got %b, required 0111", obs_can[0]);
    end
    set_walls(1);
    wall[9][10] = 1'b0;
    run_round("norev_dead");
    n_checks++;
    if (obs_can[0] !== 4'b1000) begin
      n_fail++;
      $display("FAIL norev dead end ghost 0: got %b, required 1000", obs_can[0]);
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_open_maze();
    test_tunnel();
    test_corner();
    test_random();
    test_overrun();
    test_mid_reset();
`ifdef GHOST_NO_REVERSE_EN
    test_no_reverse();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
